// File: rtl/pdn_inject.sv
// Local-core injector for one deflection-router port: queues 9-bit messages and
// serialises each into three 10-bit flits, injecting only into free link slots.
module pdn_inject #(
   parameter int FIFO_DEPTH = 4,
   parameter int LOCAL_X    = 0,
   parameter int LOCAL_Y    = 0,
   parameter int STARVE_LIM = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_dest_x,
   input  logic [1:0]  req_dest_y,
   input  logic [8:0]  req_data,
   input  logic [9:0]  link_in,
   output logic [9:0]  flit_out,
   output logic        busy,
   output logic        msg_sent,
   output logic        err_self,
   output logic        starve,
   output logic [15:0] sent_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S0   = 2'd1,
      ST_S1   = 2'd2,
      ST_S2   = 2'd3
   } state_t;

   // Queue entry layout: {dest_x[12:11], dest_y[10:9], data[8:0]}
   logic [12:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   state_t           state_reg;
   logic [12:0]      msg_reg;
   logic [9:0]       flit_reg;
   logic             req_ready_reg;
   logic             busy_reg;
   logic             msg_sent_reg;
   logic             err_self_reg;
   logic             starve_reg;
   logic [15:0]      sent_count_reg;
   logic [7:0]       starve_cnt_reg;
   logic [7:0]       starve_cnt_next;

   logic             slot_free;
   logic             is_self;
   logic             accept;
   logic             push;
   logic             pop;
   logic             stay_active;
   logic             busy_next;
   logic [1:0]       seq;
   logic [2:0]       payload;
   logic [9:0]       cur_flit;
   logic             link_unused;

   assign link_unused = ^link_in[8:0];

   always_comb begin
      slot_free   = ~link_in[9];
      is_self     = (req_dest_x == 2'(LOCAL_X)) && (req_dest_y == 2'(LOCAL_Y));
      accept      = req_valid && req_ready_reg;
      push        = accept && !is_self;
      // IDLE pops whenever work exists; S2 pops on its advance so messages chain without a bubble
      pop         = (count_reg != '0) &&
                    ((state_reg == ST_IDLE) || ((state_reg == ST_S2) && slot_free));
      stay_active = (state_reg != ST_IDLE) && !((state_reg == ST_S2) && slot_free);

      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (!push && pop)
         count_next = count_reg - 1'b1;

      busy_next = pop || stay_active || (count_next != '0);

      seq     = 2'd0;
      payload = 3'd0;
      case (state_reg)
         ST_S0: begin
            seq     = 2'd0;
            payload = msg_reg[8:6];
         end
         ST_S1: begin
            seq     = 2'd1;
            payload = msg_reg[5:3];
         end
         ST_S2: begin
            seq     = 2'd2;
            payload = msg_reg[2:0];
         end
         default: begin
            seq     = 2'd0;
            payload = 3'd0;
         end
      endcase
      cur_flit = {1'b1, msg_reg[12:11], msg_reg[10:9], seq, payload};

      // Starvation only accrues while a flit is waiting on an occupied slot
      starve_cnt_next = starve_cnt_reg;
      if ((state_reg == ST_IDLE) || slot_free)
         starve_cnt_next = 8'd0;
      else if (starve_cnt_reg < 8'(STARVE_LIM))
         starve_cnt_next = starve_cnt_reg + 8'd1;
   end

   // Storage array carries no reset; the pointers alone define the queue contents
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= {req_dest_x, req_dest_y, req_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         msg_reg        <= '0;
         flit_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         req_ready_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         msg_sent_reg   <= 1'b0;
         err_self_reg   <= 1'b0;
         starve_reg     <= 1'b0;
         starve_cnt_reg <= '0;
         sent_count_reg <= '0;
      end else begin
         msg_sent_reg   <= 1'b0;
         flit_reg       <= '0;
         err_self_reg   <= accept && is_self;
         count_reg      <= count_next;
         req_ready_reg  <= (count_next != CNT_W'(FIFO_DEPTH));
         busy_reg       <= busy_next;
         starve_cnt_reg <= starve_cnt_next;
         starve_reg     <= (starve_cnt_next == 8'(STARVE_LIM));

         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  msg_reg   <= mem[rd_ptr_reg];
                  state_reg <= ST_S0;
               end
            end
            ST_S0: begin
               if (slot_free) begin
                  flit_reg  <= cur_flit;
                  state_reg <= ST_S1;
               end
            end
            ST_S1: begin
               if (slot_free) begin
                  flit_reg  <= cur_flit;
                  state_reg <= ST_S2;
               end
            end
            ST_S2: begin
               if (slot_free) begin
                  flit_reg       <= cur_flit;
                  msg_sent_reg   <= 1'b1;
                  sent_count_reg <= sent_count_reg + 16'd1;
                  if (pop) begin
                     msg_reg   <= mem[rd_ptr_reg];
                     state_reg <= ST_S0;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_reg;
   assign flit_out   = flit_reg;
   assign busy       = busy_reg;
   assign msg_sent   = msg_sent_reg;
   assign err_self   = err_self_reg;
   assign starve     = starve_reg;
   assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_pdn_inject.sv
// Directed bench for pdn_inject: hand-derived flit sequences, back-pressure,
// self-addressed discard, mid-message reset and sent_count wrap.
module tb_pdn_inject;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_dest_x = '0;
   logic [1:0]  req_dest_y = '0;
   logic [8:0]  req_data = '0;
   logic [9:0]  link_in = '0;
   logic [9:0]  flit_out;
   logic        busy;
   logic        msg_sent;
   logic        err_self;
   logic        starve;
   logic [15:0] sent_count;

   int errors = 0;
   int checks = 0;

   pdn_inject #(
      .FIFO_DEPTH(4),
      .LOCAL_X(0),
      .LOCAL_Y(0),
      .STARVE_LIM(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_dest_x (req_dest_x),
      .req_dest_y (req_dest_y),
      .req_data   (req_data),
      .link_in    (link_in),
      .flit_out   (flit_out),
      .busy       (busy),
      .msg_sent   (msg_sent),
      .err_self   (err_self),
      .starve     (starve),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_msg(input logic [1:0] x, input logic [1:0] y, input logic [8:0] d);
      req_valid  = 1'b1;
      req_dest_x = x;
      req_dest_y = y;
      req_data   = d;
      tick();
      req_valid  = 1'b0;
   endtask

   function automatic logic [9:0] mk_flit(input logic [1:0] x, input logic [1:0] y,
                                          input logic [8:0] d, input int s);
      logic [8:0] sh;
      sh = d >> (6 - 3 * s);
      return {1'b1, x, y, 2'(s), sh[2:0]};
   endfunction

   logic [1:0] mx [5];
   logic [1:0] my [5];
   logic [8:0] md [5];

   initial begin
      mx[0] = 2'd3; my[0] = 2'd3; md[0] = 9'h1FF;
      mx[1] = 2'd1; my[1] = 2'd0; md[1] = 9'h001;
      mx[2] = 2'd2; my[2] = 2'd1; md[2] = 9'h0AA;
      mx[3] = 2'd0; my[3] = 2'd3; md[3] = 9'h155;
      mx[4] = 2'd3; my[4] = 2'd1; md[4] = 9'h123;

      // Reset state
      tick();
      check("rst_ready", 16'(req_ready), 16'd0);
      check("rst_flit", 16'(flit_out), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_count", sent_count, 16'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ready_after_release", 16'(req_ready), 16'd1);

      // Basic message, free link
      push_msg(2'd1, 2'd2, 9'h1A5);
      check("t1_busy", 16'(busy), 16'd1);
      check("t1_no_flit_yet", 16'(flit_out), 16'd0);
      tick();
      check("t1_still_empty", 16'(flit_out), 16'd0);
      tick();
      check("t1_seq0", 16'(flit_out), 16'(10'b1_01_10_00_110));
      check("t1_no_sent0", 16'(msg_sent), 16'd0);
      tick();
      check("t1_seq1", 16'(flit_out), 16'(10'b1_01_10_01_100));
      tick();
      check("t1_seq2", 16'(flit_out), 16'(10'b1_01_10_10_101));
      check("t1_msg_sent", 16'(msg_sent), 16'd1);
      check("t1_count", sent_count, 16'd1);
      tick();
      check("t1_idle_flit", 16'(flit_out), 16'd0);
      check("t1_pulse_end", 16'(msg_sent), 16'd0);
      check("t1_idle_busy", 16'(busy), 16'd0);

      // Blocked for 5 cycles in S1, starve with limit 4
      push_msg(2'd2, 2'd3, 9'h0F0);
      tick();
      tick();
      check("t2_seq0", 16'(flit_out), 16'(mk_flit(2'd2, 2'd3, 9'h0F0, 0)));
      link_in = 10'h3FF;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("t2_blocked%0d_flit", i), 16'(flit_out), 16'd0);
         check($sformatf("t2_blocked%0d_starve", i), 16'(starve), (i >= 4) ? 16'd1 : 16'd0);
      end
      link_in = 10'h000;
      tick();
      check("t2_seq1", 16'(flit_out), 16'(10'b1_10_11_01_110));
      check("t2_starve_clr", 16'(starve), 16'd0);
      tick();
      check("t2_seq2", 16'(flit_out), 16'(10'b1_10_11_10_000));
      check("t2_msg_sent", 16'(msg_sent), 16'd1);
      check("t2_count", sent_count, 16'd2);
      tick();

      // Back-pressure: one message parked in S0, then four fill the queue
      link_in = 10'h200;
      push_msg(mx[0], my[0], md[0]);
      tick();
      for (int k = 1; k <= 4; k++) begin
         push_msg(mx[k], my[k], md[k]);
         check($sformatf("t3_ready_after_push%0d", k), 16'(req_ready), (k == 4) ? 16'd0 : 16'd1);
      end
      req_valid  = 1'b1;
      req_dest_x = 2'd1;
      req_dest_y = 2'd1;
      req_data   = 9'h0C3;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("t3_held%0d_ready", i), 16'(req_ready), 16'd0);
         check($sformatf("t3_held%0d_flit", i), 16'(flit_out), 16'd0);
      end
      req_valid = 1'b0;
      link_in   = 10'h000;
      for (int k = 0; k < 5; k++) begin
         for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("t3_m%0d_seq%0d", k, s), 16'(flit_out), 16'(mk_flit(mx[k], my[k], md[k], s)));
            check($sformatf("t3_m%0d_sent%0d", k, s), 16'(msg_sent), (s == 2) ? 16'd1 : 16'd0);
         end
      end
      tick();
      check("t3_drained_flit", 16'(flit_out), 16'd0);
      check("t3_drained_busy", 16'(busy), 16'd0);
      check("t3_count", sent_count, 16'd7);

      // Self-addressed message is discarded
      push_msg(2'd0, 2'd0, 9'h1FF);
      check("t4_err_self", 16'(err_self), 16'd1);
      check("t4_busy", 16'(busy), 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t4_quiet%0d_flit", i), 16'(flit_out), 16'd0);
         check($sformatf("t4_quiet%0d_err", i), 16'(err_self), 16'd0);
         check($sformatf("t4_quiet%0d_busy", i), 16'(busy), 16'd0);
      end
      check("t4_count", sent_count, 16'd7);

      // Reset while in S1 with two messages queued
      push_msg(2'd1, 2'd1, 9'h111);
      push_msg(2'd2, 2'd2, 9'h122);
      push_msg(2'd3, 2'd0, 9'h133);
      check("t5_pre_seq0", 16'(flit_out), 16'(mk_flit(2'd1, 2'd1, 9'h111, 0)));
      rst_n = 1'b0;
      #1;
      check("t5_rst_flit", 16'(flit_out), 16'd0);
      check("t5_rst_busy", 16'(busy), 16'd0);
      check("t5_rst_ready", 16'(req_ready), 16'd0);
      check("t5_rst_count", sent_count, 16'd0);
      check("t5_rst_misc", 16'({msg_sent, err_self, starve}), 16'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t5_after%0d_flit", i), 16'(flit_out), 16'd0);
         check($sformatf("t5_after%0d_busy", i), 16'(busy), 16'd0);
      end

      // sent_count wrap
      force dut.sent_count_reg = 16'hFFFE;
      #2;
      release dut.sent_count_reg;
      check("t6_preload", sent_count, 16'hFFFE);
      push_msg(2'd0, 2'd1, 9'h0E1);
      push_msg(2'd1, 2'd3, 9'h1C2);
      tick();
      tick();
      tick();
      check("t6_first_done", 16'(msg_sent), 16'd1);
      check("t6_count_ffff", sent_count, 16'hFFFF);
      tick();
      check("t6_no_bubble", 16'(flit_out), 16'(mk_flit(2'd1, 2'd3, 9'h1C2, 0)));
      tick();
      tick();
      check("t6_second_done", 16'(msg_sent), 16'd1);
      check("t6_count_wrap", sent_count, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
